screen_line_fetcher: RTL

- Sits directly upstream of the VGA renderer.
- During horizontal blanking it prefetches one 32-byte row of the 32x32 screen RAM (base 0x200) into a double-buffered line buffer, using a req/grant handshake on the shared RAM port.
- The renderer reads pixel bytes from the front bank with 1-cycle latency and no RAM arbitration during active video.
- CPU stalls shrink to one burst per pixel row.

---
 rtl/screen_line_fetcher.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/screen_line_fetcher.sv
//==============================================================================
// Module   : screen_line_fetcher
// Purpose  : Prefetches one row of the screen RAM into a double-buffered line
//            buffer during horizontal blanking, so the renderer can read pixel
//            bytes from the front bank without arbitrating for the RAM port.
// Ports    : i_clk, i_reset       - clock, asynchronous active-high reset
//            i_line_start/i_line_row - start fetching a row into the back bank
//            i_swap               - exchange front/back banks (IDLE only)
//            o_mem_req/o_mem_addr/i_mem_grant/i_mem_data - shared RAM port
//            i_pix_x/o_pix_data   - front-bank read, 1-cycle latency
//            o_busy/o_done/o_overrun - status; overrun is sticky
//            o_fetch_cycles       - cycles taken by the last fetch
//                                   (LINE_FETCH_STATS_EN only)
// Options  : LINE_FETCH_STATS_EN  - adds the fetch_cycles counter and port
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module screen_line_fetcher #(
  parameter int                    ADDR_WIDTH  = 11,
  parameter logic [ADDR_WIDTH-1:0] SCREEN_BASE = 11'h200,
  parameter int                    COLS_LOG2   = 5,
  parameter int                    ROWS_LOG2   = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_line_start,
  input  logic [ROWS_LOG2-1:0]  i_line_row,
  input  logic                  i_swap,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_grant,
  input  logic [7:0]            i_mem_data,
  input  logic [COLS_LOG2-1:0]  i_pix_x,
  output logic [7:0]            o_pix_data,
  output logic                  o_busy,
  output logic                  o_done,
`ifdef LINE_FETCH_STATS_EN
  output logic [7:0]            o_fetch_cycles,
`endif
  output logic                  o_overrun
);

  localparam int                   c_NCOLS    = 1 << COLS_LOG2;
  localparam logic [COLS_LOG2-1:0] c_LAST_COL = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  logic [ROWS_LOG2-1:0]    r_row;
  logic [COLS_LOG2-1:0]    r_col;
  logic [COLS_LOG2-1:0]    r_cap_col;
  logic                    r_cap_valid;
  logic                    r_bank_sel;   // front bank index
  logic                    r_mem_req;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [7:0]              r_pix_data;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_overrun;

  // Both banks in one array, indexed {bank, column}.
  logic [7:0]              r_line [0:2*c_NCOLS-1];

  logic [ROWS_LOG2-1:0]    w_row;
  logic [COLS_LOG2-1:0]    w_col;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic                    w_start;

  // Address of the next request: first column of the new row when starting,
  // otherwise the column after the one just granted.
  assign w_row   = (r_state == S_IDLE) ? i_line_row : r_row;
  assign w_col   = (r_state == S_IDLE) ? '0 : r_col + 1'b1;
  assign w_addr  = SCREEN_BASE + ADDR_WIDTH'({w_row, w_col});
  assign w_start = (r_state == S_IDLE) && i_line_start;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_cap_col   <= '0;
      r_cap_valid <= 1'b0;
      r_bank_sel  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_pix_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_cap_valid <= 1'b0;
      r_pix_data  <= r_line[{r_bank_sel, i_pix_x}];

      case (r_state)
        S_IDLE: begin
          // The swap lands on the same edge the fetch starts, so capture
          // writes (which use ~r_bank_sel) target the new back bank.
          if (i_swap) begin
            r_bank_sel <= ~r_bank_sel;
          end
          if (w_start) begin
            r_row      <= i_line_row;
            r_col      <= '0;
            r_mem_addr <= w_addr;
            r_mem_req  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (i_swap || i_line_start) begin
            r_overrun <= 1'b1;
          end
          if (i_mem_grant) begin
            r_cap_valid <= 1'b1;
            r_cap_col   <= r_col;
            if (r_col == c_LAST_COL) begin
              r_mem_req <= 1'b0;
              r_state   <= S_DRAIN;
            end else begin
              r_col      <= w_col;
              r_mem_addr <= w_addr;
            end
          end
        end

        S_DRAIN: begin
          if (i_swap || i_line_start) begin
            r_overrun <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Line buffer has no reset; read data arrives the cycle after its grant.
  always_ff @(posedge i_clk) begin
    if (r_cap_valid) begin
      r_line[{~r_bank_sel, r_cap_col}] <= i_mem_data;
    end
  end

`ifdef LINE_FETCH_STATS_EN
  logic [7:0] r_cnt;
  logic [7:0] r_fetch_cycles;
  logic [7:0] w_cnt_inc;

  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt          <= '0;
      r_fetch_cycles <= '0;
    end else begin
      if (w_start) begin
        r_cnt <= '0;
      end else if (r_state == S_FETCH) begin
        r_cnt <= w_cnt_inc;
      end else if (r_state == S_DRAIN) begin
        r_fetch_cycles <= w_cnt_inc;
      end
    end
  end

  assign o_fetch_cycles = r_fetch_cycles;
`endif

  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_pix_data = r_pix_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_overrun  = r_overrun;

endmodule

`default_nettype wire
